// File: rtl/uart_rx_assembler_if.sv
// Byte-stream input and word valid/ready output bundle for uart_rx_assembler.
// The master modport is the assembler's view; slave is the surrounding logic.
interface uart_rx_assembler_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_error;
  logic [31:0] out_float;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;
  logic        timeout;
  logic [1:0]  byte_count;

  modport master (
    input  rx_data, rx_valid, rx_error, out_ready,
    output out_float, out_valid, overrun, timeout, byte_count
  );

  modport slave (
    output rx_data, rx_valid, rx_error, out_ready,
    input  out_float, out_valid, overrun, timeout, byte_count
  );
endinterface

// File: rtl/uart_rx_assembler.sv
// Reassembles LSB-first groups of four UART bytes into 32-bit words behind a
// valid/ready output register. Inter-byte timeout compiled in with UART_RX_ASSEMBLER_TIMEOUT_EN.
module uart_rx_assembler #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_rx_assembler_if.master  bus
);

  if (TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_rx_assembler: TIMEOUT_CYCLES must be at least 2");
  end

  logic [1:0]  byte_count;
  logic [23:0] asm_reg;
  logic [31:0] out_float_q;
  logic        out_valid_q;
  logic        overrun_q;

  logic accept;
  logic complete;
  logic load;
  logic timeout_hit;

  // An error in the same cycle discards the byte, so it never counts as accepted.
  assign accept   = bus.rx_valid && !bus.rx_error;
  assign complete = accept && (byte_count == 2'd3);
  assign load     = complete && (!out_valid_q || bus.out_ready);

`ifdef UART_RX_ASSEMBLER_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT_CYCLES);

  logic [GAP_W-1:0] gap_count;
  logic             timeout_q;

  // A byte (or error) in the expiry cycle takes precedence over the timeout.
  assign timeout_hit = (gap_count == GAP_MAX) && (byte_count != 2'd0) &&
                       !bus.rx_valid && !bus.rx_error;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_count <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
      if (accept || bus.rx_error || timeout_hit || byte_count == 2'd0)
        gap_count <= '0;
      else if (gap_count != GAP_MAX)
        gap_count <= gap_count + 1'b1;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_count  <= 2'd0;
      // NOTE: the assembly register is cleared too, so a partial word can never
      // leak across a reset even though byte_count alone would mask it.
      asm_reg     <= 24'd0;
      out_float_q <= 32'd0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q <= complete && !load;

      if (bus.rx_error || timeout_hit) begin
        byte_count <= 2'd0;
      end else if (accept) begin
        // 3 -> 0 wrap is the word-complete case and is intended.
        byte_count <= byte_count + 2'd1;
        case (byte_count)
          2'd0:    asm_reg[7:0]   <= bus.rx_data;
          2'd1:    asm_reg[15:8]  <= bus.rx_data;
          2'd2:    asm_reg[23:16] <= bus.rx_data;
          default: ;
        endcase
      end

      if (load) begin
        out_float_q <= {bus.rx_data, asm_reg};
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.byte_count = byte_count;
  assign bus.out_float  = out_float_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_assembler.sv
// Self-checking bench for uart_rx_assembler: directed scenarios with fixed
// expectations, then randomized traffic against a byte-queue reference model.
module tb_uart_rx_assembler;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  uart_rx_assembler_if bus ();

  uart_rx_assembler #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: pending bytes as a queue, one held word, idle cycles since last byte.
  logic [7:0]  m_part[$];
  logic [31:0] m_word;
  bit          m_valid, m_ovr, m_to;
  int          m_idle;

  task automatic m_reset();
    m_part.delete();
    m_word = 32'd0; m_valid = 0; m_ovr = 0; m_to = 0; m_idle = 0;
  endtask

  task automatic m_step(input bit v, input logic [7:0] d, input bit e, input bit r);
    bit loaded = 0;
    bit consumed = m_valid && r;
    m_ovr = 0; m_to = 0;
    if (e) begin
      m_part.delete();
      m_idle = 0;
    end else if (v) begin
      m_part.push_back(d);
      m_idle = 0;
      if (m_part.size() == 4) begin
        if (!m_valid || r) begin
          m_word = {m_part[3], m_part[2], m_part[1], m_part[0]};
          m_valid = 1;
          loaded = 1;
        end else begin
          m_ovr = 1;
        end
        m_part.delete();
      end
    end else if (m_part.size() != 0) begin
`ifdef UART_RX_ASSEMBLER_TIMEOUT_EN
      if (m_idle == TMO) begin
        m_part.delete();
        m_to = 1;
        m_idle = 0;
      end else begin
        m_idle++;
      end
`endif
    end
    if (consumed && !loaded) m_valid = 0;
  endtask

  // One clock: drive inputs, let the edge happen, sample 1 time unit later.
  task automatic cycle(input bit v, input logic [7:0] d, input bit e, input bit r);
    bus.rx_valid  = v;
    bus.rx_data   = d;
    bus.rx_error  = e;
    bus.out_ready = r;
    @(posedge clk);
    #1;
    m_step(v, d, e, r);
  endtask

  task automatic test_reset();
    bus.rx_valid = 0; bus.rx_data = 8'h00; bus.rx_error = 0; bus.out_ready = 0;
    reset = 1'b1;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_float !== 32'd0 || bus.byte_count !== 2'd0 ||
        bus.overrun !== 1'b0 || bus.timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: got valid=%b float=%h bc=%0d ovr=%b to=%b, expected all zero",
               bus.out_valid, bus.out_float, bus.byte_count, bus.overrun, bus.timeout);
    end
    reset = 1'b0;
  endtask

  task automatic test_pi();
    logic [7:0] b[4];
    b = '{8'hDB, 8'h0F, 8'h49, 8'h40};
    for (int i = 0; i < 4; i++) begin
      cycle(1, b[i], 0, 1);
      n_checks++;
      if (bus.byte_count !== 2'((i + 1) % 4)) begin
        n_errors++;
        $display("FAIL pi_byte_count[%0d]: got %0d expected %0d", i, bus.byte_count, (i + 1) % 4);
      end
    end
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_float !== 32'h40490FDB) begin
      n_errors++;
      $display("FAIL pi_word: got valid=%b float=%h expected valid=1 float=40490fdb",
               bus.out_valid, bus.out_float);
    end
    cycle(0, 8'h00, 0, 1);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL pi_one_cycle: got valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] b[8];
    b = '{8'h00, 8'h00, 8'h80, 8'h3F, 8'h00, 8'h00, 8'h00, 8'h40};
    for (int i = 0; i < 4; i++) cycle(1, b[i], 0, 0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_float !== 32'h3F800000) begin
      n_errors++;
      $display("FAIL ovr_first: got valid=%b float=%h expected valid=1 float=3f800000",
               bus.out_valid, bus.out_float);
    end
    for (int i = 4; i < 8; i++) cycle(1, b[i], 0, 0);
    n_checks++;
    if (bus.overrun !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_float !== 32'h3F800000) begin
      n_errors++;
      $display("FAIL ovr_drop: got ovr=%b valid=%b float=%h expected ovr=1 valid=1 float=3f800000",
               bus.overrun, bus.out_valid, bus.out_float);
    end
    cycle(0, 8'h00, 0, 0);
    n_checks++;
    if (bus.overrun !== 1'b0) begin
      n_errors++;
      $display("FAIL ovr_pulse_width: got ovr=%b expected 0", bus.overrun);
    end
    cycle(0, 8'h00, 0, 1);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL ovr_consume: got valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_error();
    logic [7:0] b[4];
    b = '{8'h11, 8'h22, 8'h33, 8'h44};
    cycle(1, 8'hA1, 0, 0);
    cycle(1, 8'hA2, 0, 0);
    cycle(1, 8'hA3, 1, 0);
    n_checks++;
    if (bus.byte_count !== 2'd0) begin
      n_errors++;
      $display("FAIL err_clear: got bc=%0d expected 0", bus.byte_count);
    end
    for (int i = 0; i < 4; i++) cycle(1, b[i], 0, 1);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_float !== 32'h44332211) begin
      n_errors++;
      $display("FAIL err_next_word: got valid=%b float=%h expected valid=1 float=44332211",
               bus.out_valid, bus.out_float);
    end
    cycle(0, 8'h00, 0, 1);
  endtask

  task automatic test_timeout();
`ifdef UART_RX_ASSEMBLER_TIMEOUT_EN
    cycle(1, 8'h5A, 0, 0);
    for (int i = 0; i < TMO; i++) begin
      cycle(0, 8'h00, 0, 0);
      n_checks++;
      if (bus.timeout !== 1'b0 || bus.byte_count !== 2'd1) begin
        n_errors++;
        $display("FAIL to_early[%0d]: got to=%b bc=%0d expected to=0 bc=1", i, bus.timeout, bus.byte_count);
      end
    end
    cycle(0, 8'h00, 0, 0);
    n_checks++;
    if (bus.timeout !== 1'b1 || bus.byte_count !== 2'd0) begin
      n_errors++;
      $display("FAIL to_fire: got to=%b bc=%0d expected to=1 bc=0", bus.timeout, bus.byte_count);
    end
    cycle(0, 8'h00, 0, 0);
    n_checks++;
    if (bus.timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL to_pulse_width: got to=%b expected 0", bus.timeout);
    end
    cycle(1, 8'h5A, 0, 0);
    for (int i = 0; i < TMO; i++) cycle(0, 8'h00, 0, 0);
    cycle(1, 8'h6B, 0, 0);
    n_checks++;
    if (bus.timeout !== 1'b0 || bus.byte_count !== 2'd2) begin
      n_errors++;
      $display("FAIL to_byte_wins: got to=%b bc=%0d expected to=0 bc=2", bus.timeout, bus.byte_count);
    end
    cycle(0, 8'h00, 1, 0);
`else
    cycle(1, 8'h5A, 0, 0);
    for (int i = 0; i < 2 * TMO + 8; i++) begin
      cycle(0, 8'h00, 0, 0);
      n_checks++;
      if (bus.timeout !== 1'b0 || bus.byte_count !== 2'd1) begin
        n_errors++;
        $display("FAIL persist[%0d]: got to=%b bc=%0d expected to=0 bc=1", i, bus.timeout, bus.byte_count);
      end
    end
    cycle(1, 8'h6B, 0, 1);
    cycle(1, 8'h7C, 0, 1);
    cycle(1, 8'h8D, 0, 1);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_float !== 32'h8D7C6B5A) begin
      n_errors++;
      $display("FAIL persist_word: got valid=%b float=%h expected valid=1 float=8d7c6b5a",
               bus.out_valid, bus.out_float);
    end
`endif
    cycle(0, 8'h00, 0, 1);
  endtask

  task automatic test_consume_same_cycle();
    for (int i = 0; i < 4; i++) cycle(1, 8'hC1 + 8'(i), 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 8'hD1 + 8'(i), 0, 0);
    cycle(1, 8'hD4, 0, 1);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_float !== 32'hD4D3D2D1 || bus.overrun !== 1'b0) begin
      n_errors++;
      $display("FAIL same_cycle: got valid=%b float=%h ovr=%b expected valid=1 float=d4d3d2d1 ovr=0",
               bus.out_valid, bus.out_float, bus.overrun);
    end
    cycle(0, 8'h00, 0, 1);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL same_cycle_drain: got valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_midword();
    logic [7:0] b[4];
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int i = 0; i < 4; i++) cycle(1, 8'hE1 + 8'(i), 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 8'hF1 + 8'(i), 0, 0);
    n_checks++;
    if (bus.byte_count !== 2'd3 || bus.out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_setup: got bc=%0d valid=%b expected bc=3 valid=1", bus.byte_count, bus.out_valid);
    end
    reset = 1'b1;
    #1;
    m_reset();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_float !== 32'd0 || bus.byte_count !== 2'd0 ||
        bus.overrun !== 1'b0 || bus.timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_async: got valid=%b float=%h bc=%0d ovr=%b to=%b expected all zero",
               bus.out_valid, bus.out_float, bus.byte_count, bus.overrun, bus.timeout);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1, b[i], 0, 1);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_float !== 32'hDDCCBBAA) begin
      n_errors++;
      $display("FAIL rst_after_word: got valid=%b float=%h expected valid=1 float=ddccbbaa",
               bus.out_valid, bus.out_float);
    end
    cycle(0, 8'h00, 0, 1);
  endtask

  task automatic test_random();
    int quiet = 0;
    for (int n = 0; n < 1500; n++) begin
      bit v, e, r;
      logic [7:0] d;
      d = 8'($urandom);
      r = $urandom_range(0, 1) == 1;
      if (quiet == 0 && $urandom_range(0, 39) == 0) quiet = $urandom_range(TMO - 3, TMO + 4);
      if (quiet > 0) begin
        quiet--;
        v = 0;
        e = 0;
      end else begin
        v = $urandom_range(0, 9) < 6;
        e = $urandom_range(0, 24) == 0;
      end
      cycle(v, d, e, r);
      n_checks++;
      if (bus.byte_count !== 2'(m_part.size()) || bus.out_valid !== m_valid ||
          (m_valid && bus.out_float !== m_word) || bus.overrun !== m_ovr || bus.timeout !== m_to) begin
        n_errors++;
        $display("FAIL random[%0d]: got bc=%0d valid=%b float=%h ovr=%b to=%b expected bc=%0d valid=%b float=%h ovr=%b to=%b",
                 n, bus.byte_count, bus.out_valid, bus.out_float, bus.overrun, bus.timeout,
                 m_part.size(), m_valid, m_word, m_ovr, m_to);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pi();
    test_overrun();
    test_error();
    test_timeout();
    test_consume_same_cycle();
    test_reset_midword();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
